ofdm_frame_timer: RTL and testbench

Parametrised successor to the fixed 4096-sample frame counter. Counts accepted samples and marks the cyclic-prefix (CP) and data regions of each OFDM symbol, plus symbol and frame boundaries, for the downstream CP-insert/strip, FFT-load and framing logic. FFT length, CP length and symbols-per-frame are runtime inputs. They are latched at frame start. The block runs in continuous or single-shot mode.

---
 rtl/ofdm_frame_timer.sv | 179 +++++++++++++++++
 tb/tb_ofdm_frame_timer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ofdm_frame_timer.sv
// OFDM frame timer: counts accepted samples and tags each one with CP/data region,
// symbol/frame boundary and index information, one cycle after acceptance.
module ofdm_frame_timer #(
    parameter int COUNT_SIZE = 12,
    parameter int SYM_SIZE   = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  ready_in,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  continuous,
    input  logic [COUNT_SIZE-1:0] fft_len,
    input  logic [COUNT_SIZE-1:0] cp_len,
    input  logic [SYM_SIZE-1:0]   syms_per_frame,
    output logic                  ready_out,
    output logic                  cp_flag,
    output logic                  control_signal,
    output logic                  sym_start,
    output logic                  frame_start,
    output logic                  frame_end,
    output logic [COUNT_SIZE-1:0] sample_idx,
    output logic [SYM_SIZE-1:0]   sym_idx,
    output logic                  busy,
    output logic                  cfg_err
);

    typedef enum logic [1:0] {IDLE, CP, DATA} state_t;

    localparam logic [COUNT_SIZE-1:0] CNT_ONE = 1;
    localparam logic [SYM_SIZE-1:0]   SYM_ONE = 1;

    state_t                state_reg, state_next;
    logic [COUNT_SIZE-1:0] sample_cnt_reg, sample_cnt_next;
    logic [SYM_SIZE-1:0]   sym_cnt_reg, sym_cnt_next;
    logic [COUNT_SIZE-1:0] fft_reg, fft_next;
    logic [COUNT_SIZE-1:0] cp_reg, cp_next;
    logic [SYM_SIZE-1:0]   syms_reg, syms_next;
    logic                  cfg_err_next;

    logic accept;
    logic last_cp, last_data, last_sym;
    logic cfg_ok_in;
    logic tag_sym_start, tag_frame_start, tag_frame_end;

    // Compares against len-1 stay within COUNT_SIZE bits, so the largest length never overflows.
    assign accept    = enable && ready_in && (state_reg != IDLE);
    assign last_cp   = (sample_cnt_reg == (cp_reg - CNT_ONE));
    assign last_data = (sample_cnt_reg == (fft_reg - CNT_ONE));
    assign last_sym  = (sym_cnt_reg == (syms_reg - SYM_ONE));
    assign cfg_ok_in = (fft_len != '0) && (syms_per_frame != '0);

    assign tag_sym_start   = (sample_cnt_reg == '0) &&
                             ((state_reg == CP) || ((state_reg == DATA) && (cp_reg == '0)));
    assign tag_frame_start = tag_sym_start && (sym_cnt_reg == '0);
    assign tag_frame_end   = (state_reg == DATA) && last_data && last_sym;

    assign busy = (state_reg != IDLE);

    always_comb begin
        state_next      = state_reg;
        sample_cnt_next = sample_cnt_reg;
        sym_cnt_next    = sym_cnt_reg;
        fft_next        = fft_reg;
        cp_next         = cp_reg;
        syms_next       = syms_reg;
        cfg_err_next    = 1'b0;

        if (abort) begin
            state_next      = IDLE;
            sample_cnt_next = '0;
            sym_cnt_next    = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        fft_next        = fft_len;
                        cp_next         = cp_len;
                        syms_next       = syms_per_frame;
                        sample_cnt_next = '0;
                        sym_cnt_next    = '0;
                        if (cfg_ok_in)
                            state_next = (cp_len != '0) ? CP : DATA;
                        else
                            cfg_err_next = 1'b1;
                    end
                end
                CP: begin
                    if (accept) begin
                        if (last_cp) begin
                            state_next      = DATA;
                            sample_cnt_next = '0;
                        end else begin
                            sample_cnt_next = sample_cnt_reg + CNT_ONE;
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        if (!last_data) begin
                            sample_cnt_next = sample_cnt_reg + CNT_ONE;
                        end else if (!last_sym) begin
                            sample_cnt_next = '0;
                            sym_cnt_next    = sym_cnt_reg + SYM_ONE;
                            state_next      = (cp_reg != '0) ? CP : DATA;
                        end else begin
                            sample_cnt_next = '0;
                            sym_cnt_next    = '0;
                            if (continuous) begin
                                // Frame wrap: the next frame runs on a fresh snapshot of the inputs.
                                fft_next  = fft_len;
                                cp_next   = cp_len;
                                syms_next = syms_per_frame;
                                if (cfg_ok_in) begin
                                    state_next = (cp_len != '0) ? CP : DATA;
                                end else begin
                                    state_next   = IDLE;
                                    cfg_err_next = 1'b1;
                                end
                            end else begin
                                state_next = IDLE;
                            end
                        end
                    end
                end
                default: begin
                    state_next      = IDLE;
                    sample_cnt_next = '0;
                    sym_cnt_next    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            sample_cnt_reg <= '0;
            sym_cnt_reg    <= '0;
            fft_reg        <= '0;
            cp_reg         <= '0;
            syms_reg       <= '0;
            cfg_err        <= 1'b0;
            ready_out      <= 1'b0;
            cp_flag        <= 1'b0;
            control_signal <= 1'b0;
            sym_start      <= 1'b0;
            frame_start    <= 1'b0;
            frame_end      <= 1'b0;
            sample_idx     <= '0;
            sym_idx        <= '0;
        end else begin
            state_reg      <= state_next;
            sample_cnt_reg <= sample_cnt_next;
            sym_cnt_reg    <= sym_cnt_next;
            fft_reg        <= fft_next;
            cp_reg         <= cp_next;
            syms_reg       <= syms_next;
            cfg_err        <= cfg_err_next;
            ready_out      <= accept && !abort;
            if (accept && !abort) begin
                cp_flag        <= (state_reg == CP);
                control_signal <= (state_reg == DATA);
                sample_idx     <= sample_cnt_reg;
                sym_idx        <= sym_cnt_reg;
                sym_start      <= tag_sym_start;
                frame_start    <= tag_frame_start;
                frame_end      <= tag_frame_end;
            end else begin
                // Region flags and indices hold; only the boundary pulses drop.
                sym_start   <= 1'b0;
                frame_start <= 1'b0;
                frame_end   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ofdm_frame_timer.sv
// Bench for ofdm_frame_timer: table of frame configurations plus hand-written
// continuous, config-error, abort and async-reset sequences, checked against a tag list model.
module tb_ofdm_frame_timer;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable, ready_in, start, abort, continuous;
    logic [11:0] fft_len, cp_len;
    logic [7:0]  syms_per_frame;
    logic        ready_out, cp_flag, control_signal, sym_start, frame_start, frame_end;
    logic [11:0] sample_idx;
    logic [7:0]  sym_idx;
    logic        busy, cfg_err;

    ofdm_frame_timer #(.COUNT_SIZE(12), .SYM_SIZE(8)) dut (
        .clock(clock), .reset(reset), .enable(enable), .ready_in(ready_in),
        .start(start), .abort(abort), .continuous(continuous),
        .fft_len(fft_len), .cp_len(cp_len), .syms_per_frame(syms_per_frame),
        .ready_out(ready_out), .cp_flag(cp_flag), .control_signal(control_signal),
        .sym_start(sym_start), .frame_start(frame_start), .frame_end(frame_end),
        .sample_idx(sample_idx), .sym_idx(sym_idx), .busy(busy), .cfg_err(cfg_err)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        cp;
        logic        dat;
        logic [11:0] sidx;
        logic [7:0]  yidx;
        logic        ss;
        logic        fs;
        logic        fe;
    } tag_t;

    typedef struct {
        logic [11:0] fft;
        logic [11:0] cp;
        logic [7:0]  syms;
        int          bp;
        int          exp_tags;
    } row_t;

    int   tests = 0;
    int   fails = 0;
    int   tags;
    tag_t exp_q[$];
    tag_t held;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected tag sequence of one frame, derived directly from the region layout.
    task automatic build(input int fft, input int cp, input int syms);
        tag_t t;
        for (int s = 0; s < syms; s++) begin
            for (int i = 0; i < cp; i++) begin
                t = '{cp: 1'b1, dat: 1'b0, sidx: 12'(i), yidx: 8'(s),
                      ss: (i == 0), fs: (i == 0 && s == 0), fe: 1'b0};
                exp_q.push_back(t);
            end
            for (int i = 0; i < fft; i++) begin
                t = '{cp: 1'b0, dat: 1'b1, sidx: 12'(i), yidx: 8'(s),
                      ss: (cp == 0 && i == 0), fs: (cp == 0 && i == 0 && s == 0),
                      fe: (s == syms - 1 && i == fft - 1)};
                exp_q.push_back(t);
            end
        end
    endtask

    task automatic step_check;
        tag_t act;
        tag_t e;
        @(negedge clock);
        act = '{cp: cp_flag, dat: control_signal, sidx: sample_idx, yidx: sym_idx,
                ss: sym_start, fs: frame_start, fe: frame_end};
        if (ready_out) begin
            if (exp_q.size() == 0) begin
                check("extra_tag", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("tag", longint'(act), longint'(e));
            end
            tags++;
            held = act;
        end else begin
            check("idle_pulses", {sym_start, frame_start, frame_end}, 0);
            check("hold", {cp_flag, control_signal, sample_idx, sym_idx},
                  {held.cp, held.dat, held.sidx, held.yidx});
        end
    endtask

    task automatic pulse_start;
        start = 1'b1;
        step_check();
        start = 1'b0;
    endtask

    // kind: 0 = run to completion, 1 = abort after stop_at tags, 2 = async reset after stop_at tags
    task automatic run_frame(input logic [11:0] fft, input logic [11:0] cp, input logic [7:0] syms,
                             input int bp, input int stop_at, input int kind, output int ntags);
        int cycles = 0;
        exp_q.delete();
        build(int'(fft), int'(cp), int'(syms));
        fft_len = fft; cp_len = cp; syms_per_frame = syms;
        tags = 0;
        ready_in = 1'b1; enable = 1'b1;
        pulse_start();
        check("busy_after_start", busy, 1);
        while (cycles < 20000 && !(exp_q.size() == 0 && !busy)) begin
            if (kind != 0 && tags == stop_at) break;
            ready_in = (bp != 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
            enable   = (bp != 0) ? ($urandom_range(0, 7) != 0) : 1'b1;
            step_check();
            cycles++;
        end
        ready_in = 1'b1; enable = 1'b1;
        if (cycles >= 20000) check("timeout", 1, 0);
        if (kind == 0) begin
            check("busy_end", busy, 0);
            check("queue_empty", exp_q.size(), 0);
        end else if (kind == 1) begin
            abort = 1'b1;
            @(negedge clock);
            check("abort_no_tag", ready_out, 0);
            check("abort_busy", busy, 0);
            abort = 1'b0;
            exp_q.delete();
        end else begin
            reset = 1'b1;
            #1;
            check("async_reset_outs",
                  {ready_out, cp_flag, control_signal, sym_start, frame_start, frame_end,
                   sample_idx, sym_idx, busy, cfg_err}, 0);
            @(negedge clock);
            reset = 1'b0;
            held = '0;
            exp_q.delete();
        end
        ntags = tags;
    endtask

    initial begin
        row_t rows[7];
        int   n;
        int   cycles;

        rows[0] = '{fft: 12'd8,    cp: 12'd2, syms: 8'd3, bp: 0, exp_tags: 30};
        rows[1] = '{fft: 12'd4,    cp: 12'd0, syms: 8'd2, bp: 0, exp_tags: 8};
        rows[2] = '{fft: 12'd8,    cp: 12'd2, syms: 8'd3, bp: 1, exp_tags: 30};
        rows[3] = '{fft: 12'd15,   cp: 12'd3, syms: 8'd4, bp: 1, exp_tags: 72};
        rows[4] = '{fft: 12'd1,    cp: 12'd0, syms: 8'd1, bp: 0, exp_tags: 1};
        rows[5] = '{fft: 12'd4095, cp: 12'd1, syms: 8'd1, bp: 0, exp_tags: 4096};
        rows[6] = '{fft: 12'd3,    cp: 12'd5, syms: 8'd2, bp: 1, exp_tags: 16};

        reset = 1'b1; enable = 1'b0; ready_in = 1'b0; start = 1'b0; abort = 1'b0;
        continuous = 1'b0; fft_len = '0; cp_len = '0; syms_per_frame = '0;
        held = '0;
        repeat (2) @(negedge clock);
        check("reset_state",
              {ready_out, cp_flag, control_signal, sym_start, frame_start, frame_end,
               sample_idx, sym_idx, busy, cfg_err}, 0);
        reset = 1'b0;
        @(negedge clock);

        for (int r = 0; r < 7; r++) begin
            run_frame(rows[r].fft, rows[r].cp, rows[r].syms, rows[r].bp, 0, 0, n);
            check($sformatf("tag_count_row%0d", r), n, rows[r].exp_tags);
            $display("[TB] row %0d fft=%0d cp=%0d syms=%0d bp=%0d tags=%0d",
                     r, rows[r].fft, rows[r].cp, rows[r].syms, rows[r].bp, n);
        end

        // Continuous mode: mid-frame fft_len change applies only to the next frame; start while busy ignored.
        exp_q.delete();
        build(8, 2, 3);
        build(4, 2, 3);
        fft_len = 12'd8; cp_len = 12'd2; syms_per_frame = 8'd3; continuous = 1'b1;
        tags = 0; cycles = 0;
        pulse_start();
        while (cycles < 2000 && !(exp_q.size() == 0 && !busy)) begin
            if (tags >= 1) fft_len = 12'd4;
            if (tags >= 35) continuous = 1'b0;
            start = (tags == 5);
            step_check();
            cycles++;
        end
        start = 1'b0;
        if (cycles >= 2000) check("timeout_cont", 1, 0);
        check("cont_tag_count", tags, 48);
        check("cont_busy_end", busy, 0);
        $display("[TB] continuous reconfig tags=%0d", tags);

        // Invalid configurations at start.
        fft_len = 12'd0; syms_per_frame = 8'd3;
        start = 1'b1; @(negedge clock); start = 1'b0;
        check("cfg_err_fft0", cfg_err, 1);
        check("cfg_err_busy", busy, 0);
        @(negedge clock);
        check("cfg_err_single_pulse", cfg_err, 0);
        fft_len = 12'd4; syms_per_frame = 8'd0;
        start = 1'b1; @(negedge clock); start = 1'b0;
        check("cfg_err_syms0", cfg_err, 1);
        check("cfg_err_syms0_busy", busy, 0);
        @(negedge clock);
        $display("[TB] invalid start configs checked");

        // Invalid configuration picked up at a continuous wrap.
        exp_q.delete();
        build(4, 0, 1);
        fft_len = 12'd4; cp_len = 12'd0; syms_per_frame = 8'd1; continuous = 1'b1;
        tags = 0; cycles = 0;
        pulse_start();
        while (cycles < 200 && !(exp_q.size() == 0 && !busy)) begin
            if (tags >= 1) fft_len = 12'd0;
            step_check();
            cycles++;
        end
        check("wrap_cfg_err", cfg_err, 1);
        check("wrap_busy", busy, 0);
        continuous = 1'b0;
        @(negedge clock);
        check("wrap_cfg_err_clear", cfg_err, 0);
        $display("[TB] continuous wrap with invalid config tags=%0d", tags);

        // Abort at sample 13, then a fresh frame starting at symbol 0.
        run_frame(12'd8, 12'd2, 8'd3, 0, 13, 1, n);
        check("abort_tags_before", n, 13);
        run_frame(12'd8, 12'd2, 8'd3, 0, 0, 0, n);
        check("after_abort_tags", n, 30);
        $display("[TB] abort at 13, restart tags=%0d", n);

        // Async reset mid-DATA at sample 15, then a full frame.
        run_frame(12'd8, 12'd2, 8'd3, 0, 15, 2, n);
        run_frame(12'd8, 12'd2, 8'd3, 1, 0, 0, n);
        check("after_reset_tags", n, 30);
        $display("[TB] async reset at 15, restart tags=%0d", n);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
